exec_stage: RTL

EXEC_STAGE -- requirements
Module: exec_stage

---
 rtl/exec_pkg.sv | 26 ++
 rtl/exec_mul_iter.sv | 56 +++++
 rtl/exec_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared constants for the execute stage: width, opcodes, FSM encoding
package exec_pkg;

    localparam int EXEC_W = 32;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    // Single-cycle ALU opcodes; MUL is routed separately and 11-15 are illegal
    function automatic logic op_is_alu(input logic [3:0] op);
        return op <= OP_SLTU;
    endfunction

endpackage

// File: rtl/exec_mul_iter.sv
// rtl/exec_mul_iter.sv - iterative shift-add multiplier, one multiplier bit per cycle
module exec_mul_iter
    import exec_pkg::*;
#(
    parameter int W = EXEC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] product
);

    localparam int CW = $clog2(W);

    logic          run_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  acc_d;

    // done/product are combinational during the last iteration's cycle so the
    // caller can register the result on the same edge that retires iteration W
    assign acc_d   = b_q[0] ? (acc_q + a_q) : acc_q;
    assign done    = run_q && (cnt_q == CW'(W - 1));
    assign product = acc_d;

    // Latch operands on start, then shift multiplicand left / multiplier right each cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else if (start) begin
            run_q <= 1'b1;
            cnt_q <= '0;
            acc_q <= '0;
            a_q   <= a;
            b_q   <= b;
        end else if (run_q) begin
            acc_q <= acc_d;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + CW'(1);
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - execute stage: 1-cycle ALU plus optional iterative MUL (EXEC_STAGE_MUL_EN)
module exec_stage
    import exec_pkg::*;
#(
    parameter int W = EXEC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [W-1:0] opr1,
    input  logic [W-1:0] opr2,
    input  logic [4:0]   rd_addr,
    output logic         wb_valid,
    output logic         wb_wren_n,
    output logic [4:0]   wb_rd_addr,
    output logic [W-1:0] wb_data,
    output logic         wb_illegal,
    output logic         busy
);

    logic [0:0]   state_q, state_d;
    logic         in_ready_q, in_ready_d;
    logic         wb_valid_q, wb_valid_d;
    logic         wb_wren_n_q, wb_wren_n_d;
    logic         wb_illegal_q, wb_illegal_d;
    logic [4:0]   wb_rd_q, wb_rd_d;
    logic [W-1:0] wb_data_q, wb_data_d;
    logic [4:0]   mul_rd_q, mul_rd_d;

    logic         accept;
    logic         alu_legal;
    logic [W-1:0] alu_res;
    logic [4:0]   shamt;

    logic         mul_start;
    logic         mul_done;
    logic [W-1:0] mul_product;

    assign accept    = in_valid && in_ready_q;
    assign alu_legal = op_is_alu(op);
    assign shamt     = opr2[4:0];

`ifdef EXEC_STAGE_MUL_EN
    assign mul_start = accept && (op == OP_MUL);
    assign busy      = (state_q == ST_MUL);

    exec_mul_iter #(.W(W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (opr1),
        .b       (opr2),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign mul_start   = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
    assign busy        = 1'b0;
`endif

    // Single-cycle ALU; illegal opcodes produce zero
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = opr1 + opr2;
            OP_SUB:  alu_res = opr1 - opr2;
            OP_AND:  alu_res = opr1 & opr2;
            OP_OR:   alu_res = opr1 | opr2;
            OP_XOR:  alu_res = opr1 ^ opr2;
            OP_SLL:  alu_res = opr1 << shamt;
            OP_SRL:  alu_res = opr1 >> shamt;
            OP_SRA:  alu_res = $signed(opr1) >>> shamt;
            OP_SLT:  alu_res = {{(W-1){1'b0}}, $signed(opr1) < $signed(opr2)};
            OP_SLTU: alu_res = {{(W-1){1'b0}}, opr1 < opr2};
            default: alu_res = '0;
        endcase
    end

    // Next state: accept into ALU or MUL, and retire the multiply when the engine finishes
    always_comb begin
        state_d      = state_q;
        mul_rd_d     = mul_rd_q;
        wb_valid_d   = 1'b0;
        wb_illegal_d = 1'b0;
        wb_wren_n_d  = 1'b1;
        wb_data_d    = wb_data_q;
        wb_rd_d      = wb_rd_q;
        if (mul_start) begin
            state_d  = ST_MUL;
            mul_rd_d = rd_addr;
        end else if (accept) begin
            wb_valid_d   = 1'b1;
            wb_data_d    = alu_res;
            wb_rd_d      = rd_addr;
            wb_illegal_d = !alu_legal;
            wb_wren_n_d  = !(alu_legal && (rd_addr != 5'd0));
        end
        if ((state_q == ST_MUL) && mul_done) begin
            state_d     = ST_IDLE;
            wb_valid_d  = 1'b1;
            wb_data_d   = mul_product;
            wb_rd_d     = mul_rd_q;
            wb_wren_n_d = (mul_rd_q == 5'd0);
        end
        in_ready_d = (state_d == ST_IDLE);
    end

    // State and write-back registers; reset clears everything including in_ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_wren_n_q  <= 1'b1;
            wb_illegal_q <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            mul_rd_q     <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            wb_valid_q   <= wb_valid_d;
            wb_wren_n_q  <= wb_wren_n_d;
            wb_illegal_q <= wb_illegal_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            mul_rd_q     <= mul_rd_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign wb_valid   = wb_valid_q;
    assign wb_wren_n  = wb_wren_n_q;
    assign wb_illegal = wb_illegal_q;
    assign wb_rd_addr = wb_rd_q;
    assign wb_data    = wb_data_q;

endmodule
